// File: rtl/alm_config_loader.sv
// alm_config_loader: shifts a word-wide bitstream into an ALM scan chain,
// then recirculates the chain once and compares readback CRC to load CRC.
module alm_config_loader #(
   parameter int WORD_W    = 32,
   parameter int CHAIN_LEN = 890,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              clear_async_n,
   input  logic              start,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              config_in,
   output logic              config_en,
   input  logic              config_out,
   output logic              busy,
   output logic              done,
   output logic              crc_err,
   output logic [15:0]       load_crc
);

   localparam int BW = $clog2(WORD_W + 1);
   localparam logic [CNT_W-1:0] LEN  = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);
   localparam logic [CNT_W-1:0] CONE = CNT_W'(1);
   localparam logic [BW-1:0]    FULL = BW'(WORD_W);
   localparam logic [BW-1:0]    BONE = BW'(1);
   localparam logic [15:0]      SEED = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_VERIFY,
      ST_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [WORD_W-1:0] buf_q, buf_d;
   logic [BW-1:0]     bcnt_q, bcnt_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [15:0]       lcrc_q, lcrc_d;
   logic [15:0]       rcrc_q, rcrc_d;
   logic              en_q, en_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              in_load;
   logic              shift_ld;
   logic [CNT_W-1:0]  remain;
   logic              xfer;
   logic [15:0]       rcrc_nx;

   function automatic logic [15:0] crc_step(input logic [15:0] c,
                                            input logic b);
      logic fb;
      fb = c[15] ^ b;
      return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction

   // Source handshake: ready only when the buffer can take a word that
   // the chain still has room for; never looks at s_valid.
   always_comb begin
      in_load  = (state_q == ST_LOAD);
      shift_ld = in_load && (bcnt_q != '0);
      remain   = LEN - cnt_q;
      s_ready  = in_load
                 && ((bcnt_q == '0) || ((bcnt_q == BONE) && shift_ld))
                 && (remain > CNT_W'(bcnt_q));
      xfer     = s_valid && s_ready;
      rcrc_nx  = crc_step(rcrc_q, config_out);
   end

   // Next-state logic for the load / verify sequencer.
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      bcnt_d  = bcnt_q;
      cnt_d   = cnt_q;
      lcrc_d  = lcrc_q;
      rcrc_d  = rcrc_q;
      busy_d  = busy_q;
      err_d   = err_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LOAD;
               busy_d  = 1'b1;
               err_d   = 1'b0;
               buf_d   = '0;
               bcnt_d  = '0;
               cnt_d   = '0;
               lcrc_d  = SEED;
               rcrc_d  = SEED;
            end
         end
         ST_LOAD: begin
            if (shift_ld) begin
               buf_d  = buf_q >> 1;
               bcnt_d = bcnt_q - BONE;
               cnt_d  = cnt_q + CONE;
               lcrc_d = crc_step(lcrc_q, buf_q[0]);
            end
            if (xfer) begin
               buf_d  = s_data;
               bcnt_d = FULL;
            end
            // Chain full: leftover bits of the last word are dropped.
            if (shift_ld && (cnt_q == LAST)) begin
               state_d = ST_VERIFY;
               buf_d   = '0;
               bcnt_d  = '0;
               cnt_d   = '0;
            end
         end
         ST_VERIFY: begin
            cnt_d  = cnt_q + CONE;
            rcrc_d = rcrc_nx;
            if (cnt_q == LAST) begin
               state_d = ST_DONE;
               cnt_d   = '0;
               err_d   = (rcrc_nx != lcrc_q);
               done_d  = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
      en_d = (state_d == ST_VERIFY)
             || ((state_d == ST_LOAD) && (bcnt_d != '0));
   end

   // State and output registers.
   always_ff @(posedge clk or negedge clear_async_n) begin
      if (!clear_async_n) begin
         state_q <= ST_IDLE;
         buf_q   <= '0;
         bcnt_q  <= '0;
         cnt_q   <= '0;
         lcrc_q  <= '0;
         rcrc_q  <= '0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         bcnt_q  <= bcnt_d;
         cnt_q   <= cnt_d;
         lcrc_q  <= lcrc_d;
         rcrc_q  <= rcrc_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // During verify the tail feeds the head on the same edge; a register
   // here would lengthen the loop by one bit and skew the rotation.
   assign config_in = (state_q == ST_VERIFY) ? config_out : buf_q[0];
   assign config_en = en_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign crc_err   = err_q;
   assign load_crc  = lcrc_q;

endmodule

// File: tb/tb_alm_config_loader.sv
// tb_alm_config_loader: directed tests on a 40-bit and a 64-bit chain,
// each chain modelled as a shift register driven by the DUT pins.
module tb_alm_config_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start;
   logic        s_valid;
   logic        flip;
   logic        sel;
   logic [31:0] s_data;

   logic start_a, sv_a, start_b, sv_b;
   logic rdy_a, cin_a, cen_a, cout_a, busy_a, done_a, err_a;
   logic rdy_b, cin_b, cen_b, cout_b, busy_b, done_b, err_b;
   logic [15:0] crc_a, crc_b;
   logic [39:0] chain_a = '0;
   logic [63:0] chain_b = '0;

   assign start_a = start & ~sel;
   assign sv_a    = s_valid & ~sel;
   assign start_b = start & sel;
   assign sv_b    = s_valid & sel;
   assign cout_a  = chain_a[39] ^ (flip & ~sel);
   assign cout_b  = chain_b[63];

   always @(posedge clk) if (cen_a) chain_a <= {chain_a[38:0], cin_a};
   always @(posedge clk) if (cen_b) chain_b <= {chain_b[62:0], cin_b};

   alm_config_loader #(.WORD_W(32), .CHAIN_LEN(40), .CNT_W(8)) dut_a (
      .clk(clk), .clear_async_n(rst_n), .start(start_a),
      .s_data(s_data), .s_valid(sv_a), .s_ready(rdy_a),
      .config_in(cin_a), .config_en(cen_a), .config_out(cout_a),
      .busy(busy_a), .done(done_a), .crc_err(err_a), .load_crc(crc_a)
   );

   alm_config_loader #(.WORD_W(32), .CHAIN_LEN(64), .CNT_W(7)) dut_b (
      .clk(clk), .clear_async_n(rst_n), .start(start_b),
      .s_data(s_data), .s_valid(sv_b), .s_ready(rdy_b),
      .config_in(cin_b), .config_en(cen_b), .config_out(cout_b),
      .busy(busy_b), .done(done_b), .crc_err(err_b), .load_crc(crc_b)
   );

   logic o_rdy, o_in, o_en, o_busy, o_done, o_err;
   logic [15:0] o_crc;
   assign o_rdy  = sel ? rdy_b  : rdy_a;
   assign o_in   = sel ? cin_b  : cin_a;
   assign o_en   = sel ? cen_b  : cen_a;
   assign o_busy = sel ? busy_b : busy_a;
   assign o_done = sel ? done_b : done_a;
   assign o_err  = sel ? err_b  : err_a;
   assign o_crc  = sel ? crc_b  : crc_a;

   int checks = 0;
   int failures = 0;

   int cyc_done, cyc_idle, n_en, first_en, last_en, n_acc, n_done;
   int idle_bad;
   logic busy_c1, rdy_c1, err_c1, err_done;
   logic [15:0] crc_done, b2b_crc;
   logic [21:0] rst_snap;
   logic [63:0] exp_c, got_c;

   function automatic logic [31:0] word(input bit b, input int i);
      logic [31:0] w [3];
      if (b) begin
         w[0] = 32'h12345678;
         w[1] = 32'h9ABCDEF0;
         w[2] = 32'hCAFEF00D;
      end else begin
         w[0] = 32'hA5A5A5A5;
         w[1] = 32'h000000FF;
         w[2] = 32'hDEADBEEF;
      end
      return w[(i > 2) ? 2 : i];
   endfunction

   function automatic logic sbit(input bit b, input int i);
      logic [31:0] w;
      w = word(b, i / 32);
      return w[i % 32];
   endfunction

   function automatic logic [15:0] crc_model(input bit b, input int len);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int i = 0; i < len; i++) begin
         if (c[15] ^ sbit(b, i)) c = (c << 1) ^ 16'h1021;
         else c = c << 1;
      end
      return c;
   endfunction

   function automatic logic [63:0] exp_chain(input bit b, input int len);
      logic [63:0] e;
      e = '0;
      for (int i = 0; i < len; i++) e[len - 1 - i] = sbit(b, i);
      return e;
   endfunction

   task automatic run(input bit b, input int stall_from, input int stall_len,
                      input int flip_cyc, input bit poke, input int rst_cyc,
                      input int max_cyc);
      int c;
      int idx;
      bit acc;
      cyc_done = 0; cyc_idle = 0; n_en = 0; first_en = 0; last_en = 0;
      n_acc = 0; n_done = 0; idle_bad = 0; rst_snap = '1;
      @(posedge clk); #1;
      sel = b; flip = 1'b0; start = 1'b0; s_valid = 1'b0;
      s_data = word(b, 0);
      if (poke) begin
         s_valid = 1'b1;
         for (int k = 0; k < 3; k++) begin
            #1;
            if (o_rdy || o_en || o_busy) idle_bad++;
            @(posedge clk); #1;
         end
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      idx = 0;
      c = 1;
      while (c <= max_cyc) begin
         s_valid = !(c >= stall_from && c < stall_from + stall_len);
         s_data  = word(b, idx);
         start   = poke && (c == 10 || c == 60);
         flip    = (c == flip_cyc);
         if (c == rst_cyc) rst_n = 1'b0;
         if (c == rst_cyc + 3) rst_n = 1'b1;
         #1;
         if (c == rst_cyc)
            rst_snap = {o_busy, o_rdy, o_en, o_in, o_done, o_err, o_crc};
         if (c == 1) begin
            busy_c1 = o_busy; rdy_c1 = o_rdy; err_c1 = o_err;
         end
         if (o_en) begin
            n_en++;
            if (first_en == 0) first_en = c;
            last_en = c;
         end
         if (o_done) begin
            n_done++;
            if (cyc_done == 0) begin
               cyc_done = c; err_done = o_err; crc_done = o_crc;
            end
         end
         if (cyc_done != 0 && !o_busy && cyc_idle == 0) cyc_idle = c;
         acc = s_valid && o_rdy;
         if (acc) n_acc++;
         if (cyc_idle != 0) break;
         @(posedge clk); #1;
         if (acc) idx++;
         c++;
      end
      flip = 1'b0; start = 1'b0; s_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; flip = 1'b0;
      sel = 1'b0; s_data = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy_a, rdy_a, cen_a, cin_a, done_a, err_a, crc_a} !== 22'h0) begin
         failures++;
         $display("FAIL reset_a: got %h expected 0",
                  {busy_a, rdy_a, cen_a, cin_a, done_a, err_a, crc_a});
      end
      checks++;
      if ({busy_b, rdy_b, cen_b, cin_b, done_b, err_b, crc_b} !== 22'h0) begin
         failures++;
         $display("FAIL reset_b: got %h expected 0",
                  {busy_b, rdy_b, cen_b, cin_b, done_b, err_b, crc_b});
      end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy_a, rdy_a, cen_a} !== 3'b000) begin
         failures++;
         $display("FAIL idle_after_reset: got %b expected 000",
                  {busy_a, rdy_a, cen_a});
      end
   endtask

   task automatic test_back_to_back();
      run(1'b0, 0, 0, -1, 1'b0, -10, 300);
      b2b_crc = crc_done;
      checks++;
      if ({busy_c1, rdy_c1} !== 2'b11) begin
         failures++;
         $display("FAIL b2b_cycle1: got %b expected 11", {busy_c1, rdy_c1});
      end
      checks++;
      if (first_en != 2 || last_en != 81 || n_en != 80) begin
         failures++;
         $display("FAIL b2b_enable: got first=%0d last=%0d n=%0d expected 2 81 80",
                  first_en, last_en, n_en);
      end
      checks++;
      if (cyc_done != 82 || n_done != 1 || cyc_idle != 83) begin
         failures++;
         $display("FAIL b2b_done: got done=%0d n=%0d idle=%0d expected 82 1 83",
                  cyc_done, n_done, cyc_idle);
      end
      checks++;
      if (n_acc != 2) begin
         failures++;
         $display("FAIL b2b_words: got %0d expected 2", n_acc);
      end
      checks++;
      if (err_done !== 1'b0) begin
         failures++;
         $display("FAIL b2b_crc_err: got %b expected 0", err_done);
      end
      exp_c = crc_model(1'b0, 40);
      checks++;
      if (crc_done !== exp_c[15:0]) begin
         failures++;
         $display("FAIL b2b_load_crc: got %h expected %h", crc_done, exp_c[15:0]);
      end
      exp_c = exp_chain(1'b0, 40);
      got_c = {24'h0, chain_a};
      checks++;
      if (got_c !== exp_c) begin
         failures++;
         $display("FAIL b2b_chain: got %h expected %h", got_c, exp_c);
      end
   endtask

   task automatic test_source_stall();
      run(1'b0, 33, 5, -1, 1'b0, -10, 300);
      checks++;
      if (n_en != 80 || (last_en - first_en + 1 - n_en) != 5) begin
         failures++;
         $display("FAIL stall_enable: got n=%0d gap=%0d expected 80 5",
                  n_en, last_en - first_en + 1 - n_en);
      end
      checks++;
      if (cyc_done != 87) begin
         failures++;
         $display("FAIL stall_done: got %0d expected 87", cyc_done);
      end
      checks++;
      if (crc_done !== b2b_crc || err_done !== 1'b0) begin
         failures++;
         $display("FAIL stall_crc: got %h err=%b expected %h err=0",
                  crc_done, err_done, b2b_crc);
      end
      exp_c = exp_chain(1'b0, 40);
      got_c = {24'h0, chain_a};
      checks++;
      if (got_c !== exp_c) begin
         failures++;
         $display("FAIL stall_chain: got %h expected %h", got_c, exp_c);
      end
   endtask

   task automatic test_corrupt();
      run(1'b0, 0, 0, 50, 1'b0, -10, 300);
      checks++;
      if (cyc_done != 82 || err_done !== 1'b1) begin
         failures++;
         $display("FAIL corrupt_err: got done=%0d err=%b expected 82 1",
                  cyc_done, err_done);
      end
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (err_a !== 1'b1 || busy_a !== 1'b0) begin
         failures++;
         $display("FAIL corrupt_hold: got err=%b busy=%b expected 1 0",
                  err_a, busy_a);
      end
   endtask

   task automatic test_ignored();
      run(1'b0, 0, 0, -1, 1'b1, -10, 300);
      checks++;
      if (idle_bad != 0) begin
         failures++;
         $display("FAIL ignored_idle_valid: got %0d expected 0", idle_bad);
      end
      checks++;
      if (err_c1 !== 1'b0) begin
         failures++;
         $display("FAIL ignored_err_clear: got %b expected 0", err_c1);
      end
      checks++;
      if (cyc_done != 82 || n_en != 80 || last_en != 81 || n_acc != 2
          || n_done != 1) begin
         failures++;
         $display("FAIL ignored_timing: got done=%0d en=%0d last=%0d acc=%0d nd=%0d expected 82 80 81 2 1",
                  cyc_done, n_en, last_en, n_acc, n_done);
      end
      exp_c = exp_chain(1'b0, 40);
      got_c = {24'h0, chain_a};
      checks++;
      if (got_c !== exp_c || err_done !== 1'b0) begin
         failures++;
         $display("FAIL ignored_chain: got %h err=%b expected %h err=0",
                  got_c, err_done, exp_c);
      end
   endtask

   task automatic test_reset_mid_load();
      run(1'b0, 0, 0, -1, 1'b0, 19, 40);
      checks++;
      if (rst_snap !== 22'h0) begin
         failures++;
         $display("FAIL midreset_outputs: got %h expected 0", rst_snap);
      end
      checks++;
      if (n_done != 0) begin
         failures++;
         $display("FAIL midreset_no_done: got %0d expected 0", n_done);
      end
      run(1'b0, 0, 0, -1, 1'b0, -10, 300);
      exp_c = exp_chain(1'b0, 40);
      got_c = {24'h0, chain_a};
      checks++;
      if (cyc_done != 82 || err_done !== 1'b0 || got_c !== exp_c) begin
         failures++;
         $display("FAIL midreset_reload: got done=%0d err=%b chain=%h expected 82 0 %h",
                  cyc_done, err_done, got_c, exp_c);
      end
   endtask

   task automatic test_exact_multiple();
      run(1'b1, 0, 0, -1, 1'b0, -10, 300);
      checks++;
      if (n_acc != 2 || cyc_done != 130 || n_en != 128 || last_en != 129) begin
         failures++;
         $display("FAIL exact_timing: got acc=%0d done=%0d en=%0d last=%0d expected 2 130 128 129",
                  n_acc, cyc_done, n_en, last_en);
      end
      exp_c = crc_model(1'b1, 64);
      checks++;
      if (crc_done !== exp_c[15:0] || err_done !== 1'b0) begin
         failures++;
         $display("FAIL exact_crc: got %h err=%b expected %h err=0",
                  crc_done, err_done, exp_c[15:0]);
      end
      exp_c = exp_chain(1'b1, 64);
      checks++;
      if (chain_b !== exp_c) begin
         failures++;
         $display("FAIL exact_chain: got %h expected %h", chain_b, exp_c);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_source_stall();
      test_corrupt();
      test_ignored();
      test_reset_mid_load();
      test_exact_multiple();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
